// File: rtl/dqsw_train_pkg.sv
// DQSW write-leveling training: shared types.
// State encoding and delay-line direction codes.
package dqsw_train_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_PULSE  = 3'd3,
    ST_EVAL   = 3'd4,
    ST_STEP   = 3'd5,
    ST_DONE   = 3'd6,
    ST_FAIL   = 3'd7
  } state_t;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/dqsw_sample_vote.sv
// Per-tap feedback accumulator and majority vote.
// full flags the ack that completes the sample set.
module dqsw_sample_vote
  import dqsw_train_pkg::*;
#(
  parameter int SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ack,
  input  logic fb,
  output logic full,
  output logic vote
);

  localparam int CW = $clog2(SAMPLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLES - 1);
  localparam logic [CW:0] SAMP_X = (CW + 1)'(SAMPLES);

  logic [CW-1:0] ones;
  logic [CW-1:0] nsamp;

  // Combinational so the FSM can leave PULSE on the final ack.
  assign full = ack && (nsamp == LAST);
  // Strict majority; a tie votes 0.
  assign vote = ({ones, 1'b0} > SAMP_X);

  // Count acks and the ones among them.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ones  <= '0;
      nsamp <= '0;
    end else if (ack) begin
      ones  <= ones + CW'(fb);
      nsamp <= nsamp + CW'(1);
    end
  end

endmodule

// File: rtl/dqsw_wrlvl_train_ctrl.sv
// Write-leveling sweep controller for one DQS lane.
// Steps the IOD delay until DQ feedback turns 0->1.
module dqsw_wrlvl_train_ctrl
  import dqsw_train_pkg::*;
#(
  parameter int MAX_TAPS      = 128,
  parameter int TAP_W         = 8,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] TAP_VALUE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic [1:0]       RX_DATA,
  output logic             PULSE_REQ,
  input  logic             PULSE_ACK
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SET_LAST =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] TAP_LAST =
    TAP_W'(MAX_TAPS - 1);

  state_t state;
  state_t state_nxt;

  logic [TAP_W-1:0] tap;
  logic [TAP_W-1:0] tap_value;
  logic [SW-1:0]    settle_cnt;
  logic             seen_zero;
  logic             gap;
  logic             start_ok;
  logic             ack;
  logic             fb;
  logic             clr;
  logic             full;
  logic             vote;

  assign BUSY = !(state == ST_IDLE ||
                  state == ST_DONE ||
                  state == ST_FAIL);

  assign DONE      = (state == ST_DONE);
  assign FAIL      = (state == ST_FAIL);
  assign TAP_VALUE = tap_value;

  assign DELAY_LINE_LOAD         = (state == ST_LOAD);
  assign EYE_MONITOR_CLEAR_FLAGS = (state == ST_LOAD);
  assign DELAY_LINE_MOVE         = (state == ST_STEP);
  assign DELAY_LINE_DIRECTION    = BUSY ? DIR_INC : DIR_DEC;

  // One idle cycle separates consecutive requests.
  assign PULSE_REQ = (state == ST_PULSE) && !gap;

  assign start_ok = START && !BUSY;
  assign ack      = PULSE_ACK && PULSE_REQ;
  assign fb       = RX_DATA[0] | RX_DATA[1];
  assign clr      = start_ok || (state == ST_STEP);

  dqsw_sample_vote #(
    .SAMPLES (SAMPLES)
  ) u_vote (
    .clk   (FAB_CLK),
    .rst_n (RESET_N),
    .clr   (clr),
    .ack   (ack),
    .fb    (fb),
    .full  (full),
    .vote  (vote)
  );

  // State register.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_FAIL:
        if (start_ok) state_nxt = ST_LOAD;
      ST_LOAD:
        state_nxt = ST_SETTLE;
      ST_SETTLE:
        if (DELAY_LINE_OUT_OF_RANGE)
          state_nxt = ST_FAIL;
        else if (settle_cnt == SET_LAST)
          state_nxt = ST_PULSE;
      ST_PULSE:
        if (full) state_nxt = ST_EVAL;
      ST_EVAL:
        if (vote && seen_zero)
          state_nxt = ST_DONE;
        else if (tap == TAP_LAST)
          state_nxt = ST_FAIL;
        else
          state_nxt = ST_STEP;
      ST_STEP:
        state_nxt = ST_SETTLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Tap, settle timer, zero history and result.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      tap        <= '0;
      tap_value  <= '0;
      settle_cnt <= '0;
      seen_zero  <= 1'b0;
      gap        <= 1'b0;
    end else begin
      gap <= ack && !full;
      if (state == ST_SETTLE)
        settle_cnt <= settle_cnt + SW'(1);
      else
        settle_cnt <= '0;
      if (start_ok) begin
        tap       <= '0;
        tap_value <= '0;
        seen_zero <= 1'b0;
      end
      if (state == ST_STEP)
        tap <= tap + TAP_W'(1);
      if (state == ST_EVAL) begin
        if (!vote)
          seen_zero <= 1'b1;
        if (vote && seen_zero)
          tap_value <= tap;
      end
    end
  end

endmodule

// File: tb/tb_dqsw_wrlvl_train_ctrl.sv
// Bench for dqsw_wrlvl_train_ctrl: sequencer model,
// sweep reference and per-scenario checks.
module tb_dqsw_wrlvl_train_ctrl;

  localparam int MAX_TAPS = 128;
  localparam int TAP_W    = 8;
  localparam int SETTLE   = 8;
  localparam int SAMPLES  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic oor;
  logic ack;
  logic [1:0] rx;
  logic busy, done, fail;
  logic load, move, dir, eyeclr, req;
  logic [TAP_W-1:0] tap_value;

  dqsw_wrlvl_train_ctrl #(
    .MAX_TAPS      (MAX_TAPS),
    .TAP_W         (TAP_W),
    .SETTLE_CYCLES (SETTLE),
    .SAMPLES       (SAMPLES)
  ) dut (
    .FAB_CLK                 (clk),
    .RESET_N                 (rst_n),
    .START                   (start),
    .BUSY                    (busy),
    .DONE                    (done),
    .FAIL                    (fail),
    .TAP_VALUE               (tap_value),
    .DELAY_LINE_LOAD         (load),
    .DELAY_LINE_MOVE         (move),
    .DELAY_LINE_DIRECTION    (dir),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .EYE_MONITOR_CLEAR_FLAGS (eyeclr),
    .RX_DATA                 (rx),
    .PULSE_REQ               (req),
    .PULSE_ACK               (ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-tap, per-sample DQ feedback seen by the DRAM model.
  bit pat [MAX_TAPS][SAMPLES];
  // 0: ack in first request cycle; 1: delays 0/1/7 plus
  // stray acks while no request is pending.
  int ack_mode = 0;

  int cur_tap  = 0;
  int tap_acks = 0;
  int loads = 0, moves = 0, acks = 0;
  int settle_err = 0, ack_err = 0;
  int req_err = 0, both_err = 0;

  // Sequencer/DRAM model and event monitor, on falling edges.
  initial begin
    bit armed, waiting, ack_prev, done_prev, now_ack;
    int since, wcnt, dly;
    armed = 0; waiting = 0; ack_prev = 0;
    done_prev = 0; since = 0; wcnt = 0; dly = 0;
    ack = 1'b0;
    rx  = 2'b00;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      rx  = 2'b00;
      now_ack = 0;
      if (done && fail) both_err++;
      if (ack_prev && req) req_err++;
      if (waiting && !req && rst_n) req_err++;
      if (!rst_n || !req) waiting = 0;
      if (load) begin
        loads++;
        cur_tap = 0; tap_acks = 0;
        since = 0; armed = 1;
      end else if (move) begin
        moves++;
        if (tap_acks != SAMPLES) ack_err++;
        cur_tap++; tap_acks = 0;
        since = 0; armed = 1;
      end else if (armed) begin
        since++;
      end
      if (armed && req) begin
        if (since != SETTLE + 1) settle_err++;
        armed = 0;
      end
      if (done && !done_prev && tap_acks != SAMPLES)
        ack_err++;
      done_prev = done;
      if (rst_n && req) begin
        if (!waiting) begin
          waiting = 1;
          wcnt = 0;
          case ($urandom_range(0, 2))
            0: dly = 0;
            1: dly = 1;
            default: dly = 7;
          endcase
          if (ack_mode == 0) dly = 0;
        end
        if (wcnt == dly) begin
          ack = 1'b1;
          if (cur_tap < MAX_TAPS && tap_acks < SAMPLES &&
              pat[cur_tap][tap_acks])
            rx = 2'($urandom_range(1, 3));
          tap_acks++;
          acks++;
          waiting = 0;
          now_ack = 1;
        end else begin
          wcnt++;
        end
      end else if (!req && armed && rst_n &&
                   ack_mode == 1 &&
                   $urandom_range(0, 3) == 0) begin
        ack = 1'b1;
        rx  = 2'($urandom_range(0, 3));
      end
      ack_prev = now_ack;
    end
  end

  // Sweep outcome derived from the feedback table alone.
  function automatic void ref_model(output bit ok,
                                    output int t_out,
                                    output int mv);
    bit sz;
    int ones;
    sz = 0; ok = 0; t_out = 0; mv = MAX_TAPS - 1;
    for (int t = 0; t < MAX_TAPS; t++) begin
      ones = 0;
      for (int s = 0; s < SAMPLES; s++)
        ones += int'(pat[t][s]);
      if (2 * ones > SAMPLES) begin
        if (sz) begin
          ok = 1; t_out = t; mv = t;
          return;
        end
      end else begin
        sz = 1;
      end
    end
  endfunction

  function automatic void set_step(input int k);
    for (int t = 0; t < MAX_TAPS; t++)
      for (int s = 0; s < SAMPLES; s++)
        pat[t][s] = (t >= k);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit to);
    to = 1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done || fail) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; oor = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({busy, done, fail, load, move, dir, eyeclr, req,
         tap_value} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%0d want all 0",
               {busy, done, fail, load, move, dir, eyeclr, req},
               tap_value);
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
    n_checks++;
    if ({busy, done, fail} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 000",
               {busy, done, fail});
    end
  endtask

  task automatic test_nominal();
    bit to, e_ok;
    int e_tap, e_mv, m0, s0, a0;
    set_step(37);
    ack_mode = 0;
    ref_model(e_ok, e_tap, e_mv);
    m0 = moves; s0 = settle_err; a0 = ack_err;
    pulse_start();
    n_checks++;
    if ({load, eyeclr, dir, busy} !== 4'b1111) begin
      n_fail++;
      $display("FAIL nominal_load: got %b want 1111",
               {load, eyeclr, dir, busy});
    end
    @(posedge clk); #2;
    n_checks++;
    if ({load, eyeclr} !== 2'b00) begin
      n_fail++;
      $display("FAIL nominal_load_width: got %b want 00",
               {load, eyeclr});
    end
    wait_end(20000, to);
    n_checks++;
    if ({to, done, fail, tap_value} !==
        {1'b0, e_ok, !e_ok, TAP_W'(e_tap)}) begin
      n_fail++;
      $display("FAIL nominal_result: got to=%0b d=%0b f=%0b tap=%0d want d=%0b tap=%0d",
               to, done, fail, tap_value, e_ok, e_tap);
    end
    n_checks++;
    if (moves - m0 !== e_mv) begin
      n_fail++;
      $display("FAIL nominal_moves: got %0d want %0d",
               moves - m0, e_mv);
    end
    n_checks++;
    if ({settle_err - s0, ack_err - a0} !== 64'd0) begin
      n_fail++;
      $display("FAIL nominal_timing: settle_err %0d ack_err %0d want 0 0",
               settle_err - s0, ack_err - a0);
    end
    n_checks++;
    if ({dir, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL nominal_idle_dir: got %b want 00",
               {dir, busy});
    end
  endtask

  task automatic test_ones_at_start();
    bit to, e_ok;
    int e_tap, e_mv, m0;
    set_step(20);
    for (int t = 0; t < 6; t++)
      for (int s = 0; s < SAMPLES; s++) pat[t][s] = 1;
    ref_model(e_ok, e_tap, e_mv);
    m0 = moves;
    pulse_start();
    wait_end(20000, to);
    n_checks++;
    if ({to, done, fail, tap_value} !==
        {1'b0, e_ok, !e_ok, TAP_W'(e_tap)}) begin
      n_fail++;
      $display("FAIL ones_start_result: got to=%0b d=%0b f=%0b tap=%0d want tap=%0d",
               to, done, fail, tap_value, e_tap);
    end
    n_checks++;
    if (moves - m0 !== e_mv) begin
      n_fail++;
      $display("FAIL ones_start_moves: got %0d want %0d",
               moves - m0, e_mv);
    end
  endtask

  task automatic test_majority_tie();
    bit to, e_ok;
    int e_tap, e_mv;
    for (int t = 0; t < MAX_TAPS; t++)
      for (int s = 0; s < SAMPLES; s++)
        pat[t][s] = (t < 3) ? 1'b0 : 1'($urandom);
    pat[3][0] = 1; pat[3][1] = 1;
    pat[3][2] = 0; pat[3][3] = 0;
    pat[4][0] = 1; pat[4][1] = 1;
    pat[4][2] = 1; pat[4][3] = 0;
    ref_model(e_ok, e_tap, e_mv);
    pulse_start();
    wait_end(20000, to);
    n_checks++;
    if ({to, done, fail, tap_value} !==
        {1'b0, e_ok, !e_ok, TAP_W'(e_tap)}) begin
      n_fail++;
      $display("FAIL majority_tie: got to=%0b d=%0b f=%0b tap=%0d want tap=%0d",
               to, done, fail, tap_value, e_tap);
    end
  endtask

  task automatic test_back_to_back();
    bit to, e_ok;
    int e_tap, e_mv, l0;
    set_step(10);
    ref_model(e_ok, e_tap, e_mv);
    l0 = loads;
    pulse_start();
    n_checks++;
    if ({done, fail, tap_value, load} !==
        {1'b0, 1'b0, TAP_W'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_clear: got d=%0b f=%0b tap=%0d load=%0b want 0 0 0 1",
               done, fail, tap_value, load);
    end
    wait_end(20000, to);
    n_checks++;
    if ({to, done, fail, tap_value} !==
        {1'b0, e_ok, !e_ok, TAP_W'(e_tap)}) begin
      n_fail++;
      $display("FAIL b2b_result: got to=%0b d=%0b tap=%0d want tap=%0d",
               to, done, tap_value, e_tap);
    end
    n_checks++;
    if (loads - l0 !== 1) begin
      n_fail++;
      $display("FAIL b2b_loads: got %0d want 1", loads - l0);
    end
  endtask

  task automatic test_fail_sweep();
    bit to, e_ok;
    int e_tap, e_mv, m0;
    set_step(MAX_TAPS);
    ref_model(e_ok, e_tap, e_mv);
    m0 = moves;
    pulse_start();
    wait_end(20000, to);
    n_checks++;
    if ({to, done, fail} !== {1'b0, e_ok, !e_ok}) begin
      n_fail++;
      $display("FAIL fail_sweep_result: got to=%0b d=%0b f=%0b want d=0 f=1",
               to, done, fail);
    end
    n_checks++;
    if (moves - m0 !== e_mv) begin
      n_fail++;
      $display("FAIL fail_sweep_moves: got %0d want %0d",
               moves - m0, e_mv);
    end
  endtask

  task automatic test_fail_oor();
    bit hit;
    int m0;
    set_step(MAX_TAPS);
    m0 = moves;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #2;
      if (cur_tap == 50) begin
        hit = 1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL oor_reach_tap50: got tap %0d want 50",
               cur_tap);
    end
    oor = 1'b1;
    @(posedge clk); #2;
    oor = 1'b0;
    n_checks++;
    if ({fail, done, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL oor_fail_next: got f/d/b %b want 100",
               {fail, done, busy});
    end
    repeat (20) @(posedge clk);
    #2;
    n_checks++;
    if ({moves - m0, 31'd0, fail} !== {32'd50, 31'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL oor_no_move: got moves %0d fail %0b want 50 1",
               moves - m0, fail);
    end
  endtask

  task automatic test_handshake();
    bit to, e_ok;
    int e_tap, e_mv, k;
    int m0, l0, a0, s0, e0, r0, c0;
    ack_mode = 1;
    for (int it = 0; it < 3; it++) begin
      k = $urandom_range(10, 60);
      for (int t = 0; t < MAX_TAPS; t++)
        for (int s = 0; s < SAMPLES; s++)
          pat[t][s] = (t < k) ? ($urandom_range(0, 3) == 0)
                              : ($urandom_range(0, 3) != 0);
      ref_model(e_ok, e_tap, e_mv);
      m0 = moves; l0 = loads; a0 = acks;
      s0 = settle_err; e0 = ack_err; r0 = req_err;
      pulse_start();
      to = 1;
      for (int i = 0; i < 30000; i++) begin
        if (busy && $urandom_range(0, 15) == 0)
          start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        if (done || fail) begin
          to = 0;
          break;
        end
      end
      n_checks++;
      if ({to, done, fail, tap_value} !==
          {1'b0, e_ok, !e_ok, e_ok ? TAP_W'(e_tap)
                                   : TAP_W'(0)}) begin
        n_fail++;
        $display("FAIL hs_result[%0d]: got to=%0b d=%0b f=%0b tap=%0d want d=%0b tap=%0d",
                 it, to, done, fail, tap_value, e_ok, e_tap);
      end
      n_checks++;
      if ({moves - m0, loads - l0} !== {e_mv, 32'd1}) begin
        n_fail++;
        $display("FAIL hs_moves_loads[%0d]: got %0d/%0d want %0d/1",
                 it, moves - m0, loads - l0, e_mv);
      end
      c0 = acks - a0;
      n_checks++;
      if (c0 !== SAMPLES * (e_mv + 1)) begin
        n_fail++;
        $display("FAIL hs_ack_count[%0d]: got %0d want %0d",
                 it, c0, SAMPLES * (e_mv + 1));
      end
      n_checks++;
      if ({settle_err - s0, ack_err - e0, req_err - r0}
          !== 96'd0) begin
        n_fail++;
        $display("FAIL hs_protocol[%0d]: settle %0d ack %0d req %0d want 0 0 0",
                 it, settle_err - s0, ack_err - e0, req_err - r0);
      end
    end
    ack_mode = 0;
  endtask

  task automatic test_reset_midsweep();
    bit hit, to, e_ok;
    int e_tap, e_mv, m0, l0;
    set_step(30);
    pulse_start();
    hit = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #2;
      if (cur_tap == 10 && req) begin
        hit = 1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_mid_reach: got tap %0d want 10 in PULSE",
               cur_tap);
    end
    rst_n = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if ({busy, done, fail, load, move, dir, eyeclr, req,
         tap_value} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b/%0d want all 0",
               {busy, done, fail, load, move, dir, eyeclr, req},
               tap_value);
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
    set_step(15);
    ref_model(e_ok, e_tap, e_mv);
    m0 = moves; l0 = loads;
    pulse_start();
    wait_end(20000, to);
    n_checks++;
    if ({to, done, fail, tap_value} !==
        {1'b0, e_ok, !e_ok, TAP_W'(e_tap)}) begin
      n_fail++;
      $display("FAIL rst_mid_restart: got to=%0b d=%0b tap=%0d want tap=%0d",
               to, done, tap_value, e_tap);
    end
    n_checks++;
    if ({moves - m0, loads - l0} !== {e_mv, 32'd1}) begin
      n_fail++;
      $display("FAIL rst_mid_counts: got moves %0d loads %0d want %0d 1",
               moves - m0, loads - l0, e_mv);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ones_at_start();
    test_majority_tie();
    test_back_to_back();
    test_fail_sweep();
    test_fail_oor();
    test_handshake();
    test_reset_midsweep();
    n_checks++;
    if (both_err !== 0) begin
      n_fail++;
      $display("FAIL done_and_fail: got %0d overlaps want 0",
               both_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dqsw_wrlvl_train_ctrl.md
Name: dqsw_wrlvl_train_ctrl

Overview:
- Write-leveling training controller for one DDR4 DQS lane. It sits directly upstream of the lane's DQSW training IOD.
- It drives the IOD dynamic delay line (load/move/direction) and eye-monitor flag clear.
- It requests DQS write-leveling pulses from the PHY sequencer, then samples the DRAM's DQ feedback returned through the IOD's RX_DATA.
- It sweeps taps upward until the feedback makes a 0->1 transition, then reports that tap, or a failure.

Parameters:
- MAX_TAPS, 128, number of delay taps swept; the last tap index is MAX_TAPS-1.
- TAP_W, 8, width of the tap counter and TAP_VALUE; must satisfy 2^TAP_W >= MAX_TAPS.
- SETTLE_CYCLES, 8, FAB_CLK cycles waited after a load or move before sampling; must be >= 1.
- SAMPLES, 4, write-leveling pulses sampled per tap; must be a power of 2 and >= 2.

Ports:
- FAB_CLK, in, 1, fabric clock; every port is synchronous to it.
- RESET_N, in, 1, synchronous active-low reset.
- START, in, 1, one-cycle training start; honoured only in IDLE, DONE or FAIL.
- BUSY, out, 1, high in every state other than IDLE, DONE and FAIL.
- DONE, out, 1, sticky success flag.
- FAIL, out, 1, sticky failure flag.
- TAP_VALUE, out, TAP_W, trained tap; valid while DONE is high.
- DELAY_LINE_LOAD, out, 1, one-cycle pulse that resets the IOD delay to its base value.
- DELAY_LINE_MOVE, out, 1, one-cycle pulse that steps the IOD delay by one tap.
- DELAY_LINE_DIRECTION, out, 1, step direction; 1 = increment.
- DELAY_LINE_OUT_OF_RANGE, in, 1, IOD delay-line saturation indicator.
- EYE_MONITOR_CLEAR_FLAGS, out, 1, one-cycle pulse issued together with DELAY_LINE_LOAD.
- RX_DATA, in, 2, DQ feedback from the IOD, both phases.
- PULSE_REQ, out, 1, level request for one DQS write-leveling pulse.
- PULSE_ACK, in, 1, one-cycle acknowledge from the sequencer; the DQ feedback is valid in the same cycle.

Behaviour:
- Reset values (RESET_N low at a FAB_CLK edge):
  - Every output is 0; TAP_VALUE = 0.
  - State = IDLE; all internal counters cleared.
  - Reset has priority over every other input, including in mid-sweep; the block is in IDLE on the first edge after RESET_N goes high.
- States: IDLE, LOAD, SETTLE, PULSE, EVAL, STEP, DONE, FAIL.
- IDLE, DONE or FAIL, with START = 1 at edge t:
  - Next state is LOAD; DONE, FAIL and TAP_VALUE clear.
  - tap = 0, ones = 0, nsamp = 0, seen_zero = 0.
  - DELAY_LINE_LOAD and EYE_MONITOR_CLEAR_FLAGS are high during cycle t+1 only.
- START while BUSY is ignored.
- LOAD: lasts one cycle, then goes to SETTLE.
  - DELAY_LINE_DIRECTION = 1 from LOAD until DONE or FAIL, and 0 otherwise.
- SETTLE: waits exactly SETTLE_CYCLES cycles, then goes to PULSE.
  - If DELAY_LINE_OUT_OF_RANGE = 1 in any SETTLE cycle, the next state is FAIL.
- PULSE:
  - PULSE_REQ is high and held until the cycle PULSE_ACK = 1; it drops on the following edge.
  - In the ACK cycle: fb = RX_DATA[0] | RX_DATA[1]; ones += fb; nsamp += 1.
  - If nsamp reaches SAMPLES, go to EVAL; otherwise stay in PULSE, re-asserting PULSE_REQ the next cycle after one low cycle.
  - PULSE_ACK outside PULSE is ignored.
  - There is no timeout; the sequencer guarantees the ACK.
- EVAL (one cycle), with vote = (2*ones > SAMPLES); a tie votes 0:
  - vote = 0: seen_zero = 1.
  - vote = 1 and seen_zero = 1: go to DONE with TAP_VALUE = tap.
  - Otherwise, if tap == MAX_TAPS-1: go to FAIL.
  - Otherwise: go to STEP.
  - A 1 before any 0 does not complete training; the sweep continues.
- STEP: lasts one cycle.
  - DELAY_LINE_MOVE = 1; tap += 1; ones = 0; nsamp = 0; next state SETTLE.
- DONE and FAIL:
  - The flag stays high and TAP_VALUE holds until reset or the next START.
  - DONE and FAIL are never high together.
- Counter widths:
  - ones and nsamp are log2(SAMPLES)+1 bits.
  - The settle counter is sized for SETTLE_CYCLES.
  - tap never wraps: the EVAL check prevents a STEP past MAX_TAPS-1.

Decomposition:
- Shared package dqsw_train_pkg:
  - The state enum (IDLE, LOAD, SETTLE, PULSE, EVAL, STEP, DONE, FAIL) and its 3-bit encoding.
  - Constants DIR_INC = 1 and DIR_DEC = 0.
- Sub-module dqsw_sample_vote: the ones/nsamp accumulator and majority compare, with inputs clr, ack, fb and outputs full, vote.
- The FSM, settle counter and tap counter stay in the top module.

Test Plan:
- Reset mid-sweep:
  - Stimulus: start, then drop RESET_N for one cycle while the FSM is in PULSE at tap 10.
  - Required response: all outputs 0 the next cycle; a fresh START restarts from tap 0 with exactly one LOAD pulse.
- Nominal transition:
  - Stimulus: the feedback model returns 0 for taps 0-36 and 1 from tap 37; SAMPLES = 4, immediate ACK.
  - Required response: DONE = 1, TAP_VALUE = 37, FAIL = 0; exactly 37 MOVE pulses, each followed by 8 SETTLE cycles before PULSE_REQ.
- Ones at start:
  - Stimulus: feedback is 1 for taps 0-5, 0 for taps 6-19, 1 from tap 20.
  - Required response: DONE with TAP_VALUE = 20.
- Majority and tie:
  - Stimulus: per-sample pattern 1,1,0,0 at tap 3 (tie), then 1,1,1,0 at tap 4, after zeros at taps 0-2.
  - Required response: tap 3 votes 0; DONE with TAP_VALUE = 4.
- Fail paths:
  - Stimulus (a): feedback constantly 0. Required response: FAIL after tap 127, with 127 MOVE pulses.
  - Stimulus (b): DELAY_LINE_OUT_OF_RANGE driven high during SETTLE at tap 50. Required response: FAIL on the next cycle, no further MOVE, DONE = 0.
- Handshake and START:
  - Stimulus: the sequencer delays ACK by 0, 1 and 7 cycles; START is pulsed while BUSY.
  - Required response: PULSE_REQ is held until ACK and drops the next cycle; exactly SAMPLES ACKs are counted per tap; START while BUSY has no effect.
